// File: rtl/imem_loader_pkg.sv
// Shared definitions for the IMEM byte-stream loader: memory geometry,
// header length and loader state encodings.
package imem_loader_pkg;

    localparam int IMEM_WORDLENGTH = 32;
    localparam int IMEM_CELLSIZE   = 8;
    localparam int IMEM_SIZE_BYTES = 1024;

    // The length header is one little-endian word, i.e. one byte per lane.
    localparam int HDR_BYTES = IMEM_WORDLENGTH / IMEM_CELLSIZE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } loader_state_e;

    // States in which the loader accepts stream bytes.
    function automatic logic accepts_bytes(input loader_state_e s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word assembler. Tracks which lane the next byte
// lands in and flags the byte that completes a word.
module imem_byte_packer #(
    parameter int CELLSIZE = 8,
    parameter int LANES    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         byte_en,
    input  logic [CELLSIZE-1:0]          byte_in,
    output logic [CELLSIZE*LANES-1:0]    word_next,
    output logic                         word_full
);

    localparam int IDX_W  = $clog2(LANES);
    localparam int WORD_W = CELLSIZE * LANES;

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;

    // Merge the incoming byte into its lane; the completed word is visible
    // combinationally on the cycle its last byte arrives.
    always_comb begin
        word_next = word_q;
        word_next[idx_q*CELLSIZE +: CELLSIZE] = byte_in;
        word_full = byte_en && (idx_q == IDX_W'(LANES - 1));
        idx_d     = idx_q;
        word_d    = word_q;
        if (clear) begin
            idx_d  = '0;
            word_d = '0;
        end else if (byte_en) begin
            idx_d  = idx_q + 1'b1;
            word_d = word_next;
        end
    end

    // Lane index and partial word registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory. Holds the CPU in reset
// while a session runs and reports a sticky done or error at the end.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no session since reset; waiting for start
// LEN      | collecting the 4-byte little-endian word count N
// DATA     | collecting the 4 bytes of the next payload word
// WRITE    | one-cycle word write strobe to IMEM
// CSUM     | waiting for the XOR checksum byte
// DONE     | load completed with matching checksum; waits for start
// ERROR    | length overflow or checksum mismatch; waits for start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WORDLENGTH = IMEM_WORDLENGTH,
    parameter int CELLSIZE   = IMEM_CELLSIZE,
    parameter int IMEM_SIZE  = IMEM_SIZE_BYTES,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CELLSIZE-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [WORDLENGTH-1:0] imem_addr,
    output logic [WORDLENGTH-1:0] imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [WORDLENGTH-1:0] ADDR_BASE = WORDLENGTH'(BASE_ADDR);
    localparam logic [WORDLENGTH-1:0] ADDR_STEP = WORDLENGTH'(WORDLENGTH / CELLSIZE);
    // Compared at full word width so an absurd header cannot wrap into range.
    localparam logic [WORDLENGTH-1:0] MAX_WORDS = WORDLENGTH'((IMEM_SIZE - BASE_ADDR) / 4);

    loader_state_e         state_q, state_d;
    logic [WORDLENGTH-1:0] remain_q, remain_d;
    logic [WORDLENGTH-1:0] addr_q, addr_d;
    logic [WORDLENGTH-1:0] wdata_q, wdata_d;
    logic [CELLSIZE-1:0]   csum_q, csum_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  in_ready_q, in_ready_d;
    logic                  we_q, we_d;

    logic                  xfer;
    logic                  pack_clear;
    logic                  pack_en;
    logic [WORDLENGTH-1:0] pack_word;
    logic                  pack_full;

    assign xfer    = in_valid && in_ready_q;
    assign pack_en = xfer && ((state_q == ST_LEN) || (state_q == ST_DATA));

    imem_byte_packer #(
        .CELLSIZE (CELLSIZE),
        .LANES    (HDR_BYTES)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pack_clear),
        .byte_en   (pack_en),
        .byte_in   (in_data),
        .word_next (pack_word),
        .word_full (pack_full)
    );

    // Next-state and next-output logic; outputs are registered from the
    // next state so they line up with the state they describe.
    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        csum_d     = csum_q;
        hold_d     = hold_q;
        done_d     = done_q;
        error_d    = error_q;
        pack_clear = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    csum_d     = '0;
                    addr_d     = ADDR_BASE;
                    pack_clear = 1'b1;
                    hold_d     = 1'b1;
                    state_d    = ST_LEN;
                end
            end
            ST_LEN: begin
                if (pack_full) begin
                    remain_d = pack_word;
                    if (pack_word > MAX_WORDS) begin
                        error_d = 1'b1;
                        hold_d  = 1'b0;
                        state_d = ST_ERROR;
                    end else if (pack_word == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ in_data;
                end
                if (pack_full) begin
                    wdata_d = pack_word;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d   = addr_q + ADDR_STEP;
                remain_d = remain_q - WORDLENGTH'(1);
                state_d  = (remain_q == WORDLENGTH'(1)) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                if (xfer) begin
                    hold_d = 1'b0;
                    if (in_data == csum_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_ERROR;
                    end
                end
            end
            default: begin
                hold_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = accepts_bytes(state_d);
        we_d       = (state_d == ST_WRITE);
    end

    // Loader FSM and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            remain_q   <= '0;
            addr_q     <= ADDR_BASE;
            wdata_q    <= '0;
            csum_q     <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            csum_q     <= csum_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frame table, hand-written reset sequence,
// and random frames checked against a frame-level reference model.
module tb_imem_loader;

    localparam int          BASE = 0;
    localparam logic [31:0] MAXW = 32'd256;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    typedef struct {
        logic [31:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  csum;
        int          gap;
        logic        exp_done;
        logic        exp_err;
        int          exp_nw;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] wlog_a[$];
    logic [31:0] wlog_d[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];

    imem_loader #(
        .WORDLENGTH (32),
        .CELLSIZE   (8),
        .IMEM_SIZE  (1024),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Record every IMEM write strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (imem_we) begin
            wlog_a.push_back(imem_addr);
            wlog_d.push_back(imem_wdata);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bq_t build_frame(input logic [31:0] n, input wq_t wq, input logic [7:0] cs);
        bq_t q;
        for (int b = 0; b < 4; b++) q.push_back(n[8*b +: 8]);
        if (n <= MAXW) begin
            foreach (wq[i]) begin
                for (int b = 0; b < 4; b++) q.push_back(wq[i][8*b +: 8]);
            end
            q.push_back(cs);
        end
        return q;
    endfunction

    // Frame-level reference: parse the byte list, list the expected writes,
    // XOR the payload and decide the outcome and how many bytes get consumed.
    task automatic model(input bq_t q, output bit m_done, output bit m_err, output int cons);
        logic [31:0] n;
        logic [7:0]  x;
        int          nw;
        exp_a.delete();
        exp_d.delete();
        n = {q[3], q[2], q[1], q[0]};
        if (n > MAXW) begin
            m_done = 0;
            m_err  = 1;
            cons   = 4;
            return;
        end
        nw = int'(n);
        x  = 8'h00;
        for (int i = 0; i < nw; i++) begin
            exp_a.push_back(32'(BASE + 4*i));
            exp_d.push_back({q[4+4*i+3], q[4+4*i+2], q[4+4*i+1], q[4+4*i]});
            for (int b = 0; b < 4; b++) x = x ^ q[4+4*i+b];
        end
        m_done = (q[4+4*nw] == x);
        m_err  = !m_done;
        cons   = 5 + 4*nw;
    endtask

    // Offer bytes; a byte moves only when in_valid and in_ready meet at an edge.
    task automatic send_stream(input string tag, input bq_t q, input int nbytes, input int gap);
        int  idx;
        int  cyc;
        int  budget;
        logic fire;
        idx    = 0;
        cyc    = 0;
        budget = 3*nbytes + 20;
        while (idx < nbytes && cyc < budget) begin
            @(negedge clk);
            case (gap)
                1:       in_valid = (cyc % 2 == 0);
                2:       in_valid = 1'($urandom_range(0, 1));
                default: in_valid = 1'b1;
            endcase
            in_data = q[idx];
            fire = in_valid && in_ready;
            @(posedge clk);
            if (fire) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".bytes_taken"}, 32'(idx), 32'(nbytes));
    endtask

    task automatic run_frame(input string tag, input bq_t q, input int gap,
                             input bit use_model, input logic e_done, input logic e_err, input int e_nw);
        bit m_done, m_err;
        int cons, nw;
        model(q, m_done, m_err, cons);
        wlog_a.delete();
        wlog_d.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({tag, ".hold_on"}, 32'(cpu_hold), 32'd1);
        chk({tag, ".ready_on"}, 32'(in_ready), 32'd1);
        chk({tag, ".flags_cleared"}, {30'd0, done, error}, 32'd0);
        send_stream(tag, q, cons, gap);
        repeat (3) @(negedge clk);
        chk({tag, ".done"}, 32'(done), 32'(use_model ? m_done : e_done));
        chk({tag, ".error"}, 32'(error), 32'(use_model ? m_err : e_err));
        chk({tag, ".hold_off"}, 32'(cpu_hold), 32'd0);
        chk({tag, ".ready_off"}, 32'(in_ready), 32'd0);
        chk({tag, ".we_idle"}, 32'(imem_we), 32'd0);
        nw = use_model ? exp_a.size() : e_nw;
        chk({tag, ".nwrites"}, 32'(wlog_a.size()), 32'(nw));
        foreach (exp_a[i]) begin
            if (i < wlog_a.size()) begin
                chk($sformatf("%s.addr%0d", tag, i), wlog_a[i], exp_a[i]);
                chk($sformatf("%s.data%0d", tag, i), wlog_d[i], exp_d[i]);
            end
        end
    endtask

    initial begin
        vec_t tbl[6];
        wq_t  wq;
        bq_t  q;
        bq_t  frame1;

        tbl[0] = '{32'd2,          32'h08000001, 32'h00221820, 8'h13, 0, 1'b1, 1'b0, 2};
        tbl[1] = '{32'd2,          32'h08000001, 32'h00221820, 8'h12, 0, 1'b0, 1'b1, 2};
        tbl[2] = '{32'h00000101,   32'h0,        32'h0,        8'h00, 0, 1'b0, 1'b1, 0};
        tbl[3] = '{32'd0,          32'h0,        32'h0,        8'h00, 0, 1'b1, 1'b0, 0};
        tbl[4] = '{32'hFFFFFFFF,   32'h0,        32'h0,        8'h00, 0, 1'b0, 1'b1, 0};
        tbl[5] = '{32'd1,          32'hDEADBEEF, 32'h0,        8'h22, 1, 1'b1, 1'b0, 1};

        // Reset state while reset is held low.
        repeat (3) @(negedge clk);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.imem_we", 32'(imem_we), 32'd0);
        chk("rst.imem_addr", imem_addr, 32'(BASE));
        chk("rst.imem_wdata", imem_wdata, 32'd0);
        chk("rst.flags", {29'd0, cpu_hold, done, error}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed frame table.
        for (int v = 0; v < 6; v++) begin
            wq.delete();
            if (tbl[v].n >= 32'd1) wq.push_back(tbl[v].w0);
            if (tbl[v].n >= 32'd2) wq.push_back(tbl[v].w1);
            q = build_frame(tbl[v].n, wq, tbl[v].csum);
            run_frame($sformatf("vec%0d", v), q, tbl[v].gap, 1'b0,
                      tbl[v].exp_done, tbl[v].exp_err, tbl[v].exp_nw);
        end

        // Reset in the middle of the first payload word.
        wq.delete();
        wq.push_back(32'h08000001);
        wq.push_back(32'h00221820);
        frame1 = build_frame(32'd2, wq, 8'h13);
        wlog_a.delete();
        wlog_d.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        send_stream("midrst", frame1, 6, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst.in_ready", 32'(in_ready), 32'd0);
        chk("midrst.imem_we", 32'(imem_we), 32'd0);
        chk("midrst.imem_addr", imem_addr, 32'(BASE));
        chk("midrst.imem_wdata", imem_wdata, 32'd0);
        chk("midrst.flags", {29'd0, cpu_hold, done, error}, 32'd0);
        repeat (2) @(negedge clk);
        chk("midrst.nwrites", 32'(wlog_a.size()), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        run_frame("after_rst", frame1, 0, 1'b0, 1'b1, 1'b0, 2);

        // Random frames against the reference model.
        for (int r = 0; r < 20; r++) begin
            int          sel;
            int          gap;
            logic [31:0] n;
            logic [7:0]  x;
            logic [7:0]  cs;
            sel = $urandom_range(0, 9);
            if (sel <= 6)      n = 32'(sel);
            else if (sel == 7) n = 32'd256;
            else if (sel == 8) n = 32'd257;
            else               n = 32'h80000000 | $urandom;
            gap = (n == 32'd256) ? 0 : $urandom_range(0, 2);
            wq.delete();
            x = 8'h00;
            if (n <= MAXW) begin
                for (int i = 0; i < int'(n); i++) begin
                    logic [31:0] w;
                    w = $urandom;
                    wq.push_back(w);
                    x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
                end
            end
            cs = ($urandom_range(0, 3) == 0) ? (x ^ 8'(1 + $urandom_range(0, 254))) : x;
            q = build_frame(n, wq, cs);
            run_frame($sformatf("rnd%0d", r), q, gap, 1'b1, 1'b0, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory: a byte-stream loader that fills IMEM before the core runs.
- Accepts a framed little-endian byte stream over a valid/ready handshake: 4-byte length header, payload, XOR checksum.
- Packs each 4 payload bytes into a word and issues one word write per word to the IMEM write port.
- Holds the CPU in reset while loading; reports done/error.

Parameters:
- WORDLENGTH, 32, instruction/word width in bits; must equal 4*CELLSIZE
- CELLSIZE, 8, memory cell (byte) width in bits
- IMEM_SIZE, 1024, IMEM capacity in bytes
- BASE_ADDR, 0, byte address of the first word written; word-aligned

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a load session (honoured in IDLE, DONE and ERROR only)
- in_data  input  CELLSIZE  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts in_data this cycle
- imem_we  output  1  one-cycle word write strobe
- imem_addr  output  WORDLENGTH  byte address of write, low 2 bits always 0
- imem_wdata  output  WORDLENGTH  word; byte0 in [CELLSIZE-1:0] (little-endian)
- cpu_hold  output  1  high while a session is active
- done  output  1  sticky, load completed with good checksum
- error  output  1  sticky, length overflow or checksum mismatch

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low.
- Reset: state=IDLE; in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=0, done=0, error=0; internal byte index, word count and checksum accumulator are cleared.
- A byte transfers only on a cycle with in_valid&&in_ready.
- States: IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR.
- IDLE, DONE, ERROR: in_ready=0. On start: clear done/error/checksum, set imem_addr=BASE_ADDR and byte index=0, assert cpu_hold, go to LEN.
- LEN: in_ready=1. Collects 4 bytes into N (little-endian word count).
  - After the 4th byte, if N > (IMEM_SIZE-BASE_ADDR)/4, go to ERROR.
  - Else if N==0, go to CSUM.
  - Else go to DATA.
- DATA: in_ready=1. Each accepted byte goes into byte lane = index and is XORed into the checksum. After the 4th byte, go to WRITE.
- WRITE: exactly 1 cycle; in_ready=0; imem_we=1 with the assembled word and current address.
  - Next cycle: address += 4, remaining count -= 1.
  - If remaining count is now 0, go to CSUM; else go to DATA.
- CSUM: in_ready=1. On one accepted byte, go to DONE if byte == checksum, else ERROR.
- DONE: done=1, cpu_hold=0. ERROR: error=1, cpu_hold=0, no further writes.
- done/error are sticky until the next start or reset.
- Throughput: 5 cycles per word at best (4 byte cycles + WRITE). in_valid gaps stall without loss.
- imem_addr and imem_wdata hold their values outside WRITE; imem_we is high only in WRITE.
- start while in LEN/DATA/WRITE/CSUM: ignored.
- Reset mid-session: immediately aborts to reset values. A partial word is never written. Words already written stay in IMEM.
- Counter widths: N is WORDLENGTH bits. The overflow compare is done at WORDLENGTH width, so N=0xFFFFFFFF must flag error, not wrap.
- Last writable word address is BASE_ADDR + 4*(N-1) <= IMEM_SIZE-4.

Decomposition:
- Shared defines header (existing): WORDLENGTH, CELLSIZE, IMEM_SIZE. Add the loader state encodings and the 4-byte header length there.
- One natural sub-module: imem_byte_packer. It holds the byte index counter and the little-endian word assembly register, and signals word_full. The FSM, address/count and checksum stay in the top module.

Test Plan:
- Load N=2, words 0x08000001 and 0x00221820 (stream 02 00 00 00 | 01 00 00 08 | 20 18 22 00 | csum 0x13) -> two imem_we pulses: addr 0x0 data 0x08000001, then addr 0x4 data 0x00221820; done=1, error=0, cpu_hold falls.
- Same frame with checksum byte 0x12 -> both words written, error=1, done=0.
- Header N=0x00000101 with IMEM_SIZE=1024 -> ERROR right after the 4th header byte; no imem_we ever; in_ready=0.
- N=0 followed by checksum 0x00 -> done=1, no writes. N=0xFFFFFFFF -> error=1.
- N=1 with in_valid toggling every other cycle -> single write of the correct word; no byte lost or duplicated.
- Assert reset (low) after 2 payload bytes of word 1 -> outputs at reset values within the same cycle, no write. Then start plus a full frame -> clean load from BASE_ADDR.
